// File: rtl/alu_ctrl_issue.sv
// ALU control decode and issue stage: registers the ALU select code
// and stretches multiplies. Optional ALU_ILLEGAL_TRAP_EN adds o_illegal.
module alu_ctrl_issue #(
  parameter int MULT_LAT = 3,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic [1:0] i_aluop,
  input  logic [5:0] i_funct,
  output logic [3:0] o_sel,
  output logic       o_valid,
  input  logic       i_ready,
`ifdef ALU_ILLEGAL_TRAP_EN
  output logic       o_illegal,
`endif
  output logic       o_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    MUL  = 2'd2
  } state_t;

  localparam logic [3:0] SEL_AND = 4'b0000;
  localparam logic [3:0] SEL_OR  = 4'b0001;
  localparam logic [3:0] SEL_ADD = 4'b0010;
  localparam logic [3:0] SEL_MUL = 4'b0011;
  localparam logic [3:0] SEL_SUB = 4'b0110;
  localparam logic [3:0] SEL_SLT = 4'b0111;

`ifdef ALU_ILLEGAL_TRAP_EN
  localparam logic [3:0] SEL_ILL = SEL_ADD;
`else
  localparam logic [3:0] SEL_ILL = SEL_AND;
`endif

  state_t           r_state;
  state_t           w_next;
  logic [3:0]       r_sel;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       w_dec;
  logic             w_ill;
  logic             w_load;
  logic             w_mul;

  // decode aluop/funct into the ALU select code
  always_comb begin
    w_dec = SEL_ADD;
    w_ill = 1'b0;
    unique case (i_aluop)
      2'b00: w_dec = SEL_ADD;
      2'b01: w_dec = SEL_SUB;
      2'b11: w_dec = SEL_OR;
      default: begin
        unique case (i_funct)
          6'b100000: w_dec = SEL_ADD;
          6'b100010: w_dec = SEL_SUB;
          6'b100100: w_dec = SEL_AND;
          6'b100101: w_dec = SEL_OR;
          6'b101010: w_dec = SEL_SLT;
          6'b011000: w_dec = SEL_MUL;
          default: begin
            w_dec = SEL_ILL;
            w_ill = 1'b1;
          end
        endcase
      end
    endcase
  end

  assign o_ready = (r_state == IDLE) ||
                   ((r_state == HOLD) && i_ready);
  assign w_load  = i_valid && o_ready;
  assign w_mul   = (w_dec == SEL_MUL) && !w_ill &&
                   (MULT_LAT > 1);

  // next-state logic; a multiply of latency 1 behaves like any other op
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_load) w_next = w_mul ? MUL : HOLD;
      end
      HOLD: begin
        if (w_load)       w_next = w_mul ? MUL : HOLD;
        else if (i_ready) w_next = IDLE;
      end
      MUL: begin
        if (r_cnt <= CNT_W'(1)) w_next = HOLD;
      end
      default: w_next = IDLE;
    endcase
  end

  // state, select and multiply counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_sel   <= 4'b0000;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_sel <= w_dec;
        r_cnt <= CNT_W'(MULT_LAT - 1);
      end else if (r_state == MUL) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

`ifdef ALU_ILLEGAL_TRAP_EN
  logic r_illegal;

  // sticky flag; illegal ops never multiply so it rises with o_valid
  always_ff @(posedge clk) begin
    if (reset)              r_illegal <= 1'b0;
    else if (w_load && w_ill) r_illegal <= 1'b1;
  end

  assign o_illegal = r_illegal;
`endif

  assign o_sel   = r_sel;
  assign o_valid = (r_state == HOLD);
  assign o_busy  = (r_state == MUL);

endmodule

// File: tb/tb_alu_ctrl_issue.sv
// Directed self-checking bench for alu_ctrl_issue (MULT_LAT=3).
// Build with ALU_ILLEGAL_TRAP_EN defined to cover the trap variant.
module tb_alu_ctrl_issue;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_valid;
  logic       o_ready;
  logic [1:0] i_aluop;
  logic [5:0] i_funct;
  logic [3:0] o_sel;
  logic       o_valid;
  logic       i_ready;
  logic       o_busy;
`ifdef ALU_ILLEGAL_TRAP_EN
  logic       o_illegal;
`endif

  int checks = 0;
  int errors = 0;
  bit seen_v;

  always #5 clk = ~clk;

  alu_ctrl_issue #(.MULT_LAT(3), .CNT_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_aluop  (i_aluop),
    .i_funct  (i_funct),
    .o_sel    (o_sel),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
`ifdef ALU_ILLEGAL_TRAP_EN
    .o_illegal(o_illegal),
`endif
    .o_busy   (o_busy)
  );

  task automatic chk(input string tag, input logic [3:0] obs,
                     input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [5:0] fn);
    i_valid = 1'b1;
    i_aluop = op;
    i_funct = fn;
  endtask

  initial begin
    reset   = 1'b1;
    i_valid = 1'b0;
    i_aluop = 2'b00;
    i_funct = 6'b0;
    i_ready = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
    chk("rst_valid", {3'b0, o_valid}, 4'h0);
    chk("rst_ready", {3'b0, o_ready}, 4'h1);
    chk("rst_sel", o_sel, 4'b0000);
    chk("rst_busy", {3'b0, o_busy}, 4'h0);
`ifdef ALU_ILLEGAL_TRAP_EN
    chk("rst_ill", {3'b0, o_illegal}, 4'h0);
`endif

    // back-to-back R-type
    issue(2'b10, 6'b100000);
    step();
    chk("b2b0_valid", {3'b0, o_valid}, 4'h1);
    chk("b2b0_sel", o_sel, 4'b0010);
    chk("b2b0_ready", {3'b0, o_ready}, 4'h1);
    issue(2'b10, 6'b100010);
    step();
    chk("b2b1_valid", {3'b0, o_valid}, 4'h1);
    chk("b2b1_sel", o_sel, 4'b0110);
    chk("b2b1_ready", {3'b0, o_ready}, 4'h1);
    issue(2'b10, 6'b101010);
    step();
    chk("b2b2_valid", {3'b0, o_valid}, 4'h1);
    chk("b2b2_sel", o_sel, 4'b0111);
    issue(2'b10, 6'b100100);
    step();
    chk("and_sel", o_sel, 4'b0000);
    issue(2'b10, 6'b100101);
    step();
    chk("or_sel", o_sel, 4'b0001);
    issue(2'b11, 6'b000000);
    step();
    chk("ori_sel", o_sel, 4'b0001);
    issue(2'b00, 6'b111000);
    step();
    chk("lw_sel", o_sel, 4'b0010);
    i_valid = 1'b0;
    step();
    chk("b2b_idle", {3'b0, o_valid}, 4'h0);

    // stall
    issue(2'b01, 6'b000000);
    i_ready = 1'b0;
    step();
    i_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("stall_valid", {3'b0, o_valid}, 4'h1);
      chk("stall_sel", o_sel, 4'b0110);
      chk("stall_ready", {3'b0, o_ready}, 4'h0);
      if (k < 3) step();
    end
    i_ready = 1'b1;
    #1;
    chk("stall_rel_ready", {3'b0, o_ready}, 4'h1);
    step();
    chk("stall_idle", {3'b0, o_valid}, 4'h0);

    // multiply, latency 3
    issue(2'b10, 6'b011000);
    step();
    i_valid = 1'b0;
    chk("mul1_busy", {3'b0, o_busy}, 4'h1);
    chk("mul1_ready", {3'b0, o_ready}, 4'h0);
    chk("mul1_valid", {3'b0, o_valid}, 4'h0);
    step();
    chk("mul2_busy", {3'b0, o_busy}, 4'h1);
    chk("mul2_ready", {3'b0, o_ready}, 4'h0);
    chk("mul2_valid", {3'b0, o_valid}, 4'h0);
    step();
    chk("mul3_valid", {3'b0, o_valid}, 4'h1);
    chk("mul3_sel", o_sel, 4'b0011);
    chk("mul3_busy", {3'b0, o_busy}, 4'h0);
    step();
    chk("mul_idle", {3'b0, o_valid}, 4'h0);

    // reset mid-multiply
    issue(2'b10, 6'b011000);
    step();
    i_valid = 1'b0;
    chk("rmul_busy", {3'b0, o_busy}, 4'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rmul_busy0", {3'b0, o_busy}, 4'h0);
    chk("rmul_ready", {3'b0, o_ready}, 4'h1);
    seen_v = o_valid;
    for (int k = 0; k < 4; k++) begin
      step();
      seen_v = seen_v | o_valid;
    end
    chk("rmul_novalid", {3'b0, seen_v}, 4'h0);

    // illegal funct
    issue(2'b10, 6'b111111);
    step();
    chk("ill_valid", {3'b0, o_valid}, 4'h1);
`ifdef ALU_ILLEGAL_TRAP_EN
    chk("ill_sel", o_sel, 4'b0010);
    chk("ill_flag", {3'b0, o_illegal}, 4'h1);
`else
    chk("ill_sel", o_sel, 4'b0000);
`endif
    issue(2'b01, 6'b000000);
    step();
    chk("post_ill_sel", o_sel, 4'b0110);
`ifdef ALU_ILLEGAL_TRAP_EN
    chk("ill_sticky1", {3'b0, o_illegal}, 4'h1);
`endif
    issue(2'b10, 6'b100101);
    step();
    i_valid = 1'b0;
    chk("post_ill_sel2", o_sel, 4'b0001);
`ifdef ALU_ILLEGAL_TRAP_EN
    chk("ill_sticky2", {3'b0, o_illegal}, 4'h1);
`endif
    step();
    chk("end_idle", {3'b0, o_valid}, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_issue.md
Name: alu_ctrl_issue

Overview:
- Producer side of the ALU select interface. Decodes the main-control ALUOp and the instruction funct field into the 4-bit ALU Sel code.
- Registers Sel as the ID/EX stage boundary and presents it to the ALU with a valid/ready handshake.
- Stretches multiply operations over a configurable number of cycles, holding Sel stable and back-pressuring the decode stage until the multiply completes.

Parameters:
- MULT_LAT, 3, cycles Sel=0011 is held before the result is declared valid; legal range 1..15.
- CNT_W, 4, width of the multiply cycle counter; must satisfy 2^CNT_W > MULT_LAT.

Ports:
- clk  input  1  single rising-edge clock
- reset  input  1  synchronous, active-high reset
- i_valid  input  1  upstream has an instruction to issue
- o_ready  output  1  block can accept an instruction this cycle
- i_aluop  input  2  00 add (lw/sw), 01 sub (beq), 10 R-type (use funct), 11 or (ori)
- i_funct  input  6  instruction bits [5:0]
- o_sel  output  4  ALU select code
- o_valid  output  1  o_sel is final and the ALU result may be captured
- i_ready  input  1  EX stage consumes the result this cycle
- o_busy  output  1  a multiply is in progress

Behaviour:
- Decode rules:
  - aluop 00 -> 0010; 01 -> 0110; 11 -> 0001.
  - aluop 10: funct 100000 -> 0010, 100010 -> 0110, 100100 -> 0000, 100101 -> 0001, 101010 -> 0111, 011000 -> 0011.
  - Any other funct is illegal; see Optional Feature.
- Transfers: an input transfer occurs when i_valid && o_ready; an output transfer occurs when o_valid && i_ready.
- FSM states: IDLE, HOLD, MUL.
  - IDLE: o_ready=1, o_valid=0. On input transfer, register the decoded sel. If sel==0011, load count=MULT_LAT-1 and go to MUL (if MULT_LAT==1, go to HOLD directly). Otherwise go to HOLD.
  - MUL: o_ready=0, o_valid=0, o_busy=1, o_sel held. Count decrements every cycle; at count==0 go to HOLD.
  - HOLD: o_valid=1, o_sel held, o_ready=i_ready.
    - Output transfer with a simultaneous input transfer: load the new decode in the same cycle, with the same branch rules as IDLE.
    - Output transfer with no input: go to IDLE.
    - No output transfer (i_ready=0): stay in HOLD, o_sel unchanged.
- Latency: non-multiply ops, o_valid 1 cycle after the input transfer. Multiply, o_valid MULT_LAT cycles after the input transfer.
- Throughput: 1 op/cycle for back-to-back non-multiply ops with i_ready held high.
- Outputs are registered, except o_ready, which is combinational from state and i_ready.
- Reset: state=IDLE, o_sel=4'b0000, o_valid=0, o_busy=0, count=0. Reset mid-multiply aborts the op with no o_valid pulse. Reset has priority over every other event.
- o_sel is 4'b0000 whenever in IDLE after reset, and keeps its last value in IDLE after a transfer. The bench must not check o_sel while o_valid=0.

Optional Feature:
- Macro: ALU_ILLEGAL_TRAP_EN.
- Defined:
  - Adds output port o_illegal (1 bit), reset 0.
  - An illegal funct is still accepted and issues o_sel=0010 (add).
  - o_illegal is a sticky flag, set in the same cycle o_valid first asserts for that op; cleared only by reset.
- Undefined:
  - No o_illegal port.
  - An illegal funct issues o_sel=0000 (and) with normal 1-cycle latency and no other indication.

Test Plan:
- Reset then idle: assert reset 2 cycles, release -> o_valid=0, o_ready=1, o_sel=0000, o_busy=0.
- Back-to-back R-type: funct 100000, 100010, 101010 with i_aluop=10 on consecutive cycles, i_ready=1 -> o_valid high 3 consecutive cycles with o_sel 0010, 0110, 0111; o_ready stays 1.
- Stall: issue aluop=01, hold i_ready=0 for 4 cycles -> o_sel=0110 and o_valid=1 stable, o_ready=0; release -> one output transfer, then IDLE.
- Multiply, MULT_LAT=3: funct 011000 -> o_busy=1 and o_ready=0 for 2 cycles, o_valid=1 with o_sel=0011 on the 3rd cycle after acceptance.
- Reset mid-multiply: assert reset during MUL -> next cycle state=IDLE, o_busy=0, o_valid never asserted for that op.
- Illegal funct 111111, aluop=10:
  - ALU_ILLEGAL_TRAP_EN defined: o_sel=0010, o_illegal=1 and stays 1 through the next legal ops.
  - Undefined: o_sel=0000.
